mstr_seq_fault_log: RTL
=======================

// Module: mstr_seq_fault_log
// PURPOSE
// - Downstream of the master power sequencer; records its 7 active-low fault flags.
//   Flag order: AUX/FAN/N1N2/PERST sequencing faults, then AUX/FAN/N1N2 runtime faults.
// - Falling edge (fault onset) on a flag -> one 24-bit record pushed into a FIFO:
//   fault code, sequencer state at onset, ms timestamp. BMC-facing logic drains the FIFO.
// - Latches the first fault since clear for the front-panel debug port.
// PARAMETERS
// - LOG_DEPTH_W   2      FIFO depth = 2**LOG_DEPTH_W records (legal 1..4)
// - TS_W          16     timestamp width in ms; saturates, never wraps
// PORTS
// - iClk           in   1      module clock; the only clock
// - iRst           in   1      synchronous reset, active-high
// - iTick_1ms      in   1      1-cycle pulse every 1 ms, synchronous to iClk
// - iFSM_state     in   4      sequencer debug state; IDLE encoding = 4'h9
// - iFlt_n         in   7      fault flags, active-low; bit0..bit6 in PURPOSE order
// - iClear_log     in   1      pulse: flush FIFO, clear timestamp/first/overflow
// - iRd_ack        in   1      pop head record; ignored when oRd_valid=0
// - oRd_valid      out  1      FIFO not empty (first-word-fall-through)
// - oRd_data       out  8+TS_W {code[3:0], state[3:0], ts[TS_W-1:0]} of head record
// - oFirst_code    out  4      code of first record logged since clear; 0 = none
// - oFault_any     out  1      1 while any iFlt_n bit is low (registered)
// - oOverflow      out  1      sticky: a record was dropped because FIFO was full
// BEHAVIOUR
// - Reset (iRst=1 at posedge): FIFO empty, oRd_valid=0, oRd_data=0, oFirst_code=0,
//   oFault_any=0, oOverflow=0, timestamp=0, pending mask=0, prev flags=7'h7F.
// - Edge detect: rPrev<=iFlt_n each cycle; edge[i]=rPrev[i]&~iFlt_n[i].
//   A flag already low when reset releases logs exactly once (prev resets to 1).
// - Pending mask: rPend <= (rPend | edge) & ~served. Each cycle the lowest set rPend
//   bit i is served: if not full, write record code=i+1 (1..7); if full, drop it
//   and set oOverflow. At most one write per cycle; multiple simultaneous edges
//   drain over consecutive cycles. An edge on an already-pending bit merges.
// - Record captures iFSM_state and timestamp of the serve cycle, not the edge cycle.
// - Latency: isolated edge in cycle N -> oRd_valid=1 in cycle N+2 (empty FIFO).
// - Timestamp: +1 on iTick_1ms, holds at all-ones (2**TS_W-1).
// - FIFO: pointer-based, LOG_DEPTH_W+1-bit pointers, full/empty by MSB compare.
//   Pop and push in the same cycle are both honoured, including when full
//   (the push is not dropped) and when empty (push only; pop ignored).
// - oFirst_code: loaded with the code of the first successful write after
//   reset/clear; then held until the next reset/clear.
// - oFault_any <= ~&iFlt_n, one cycle behind the inputs.
// - iClear_log: same-cycle priority over push, pop, edge and tick; clears FIFO,
//   rPend, timestamp, oFirst_code, oOverflow. rPrev still updates, so a flag low
//   through a clear is not re-logged.
// - Reset mid-drain: all state returns to reset values; pending records are lost.
// CONFIGURATION
// - `MSTR_FLT_LOG_IDLE_MASK_EN defined: edges detected while iFSM_state==4'h9 are
//   discarded (never enter rPend). Bits already pending are still served.
// - Not defined: edges are logged in every state.
// TESTING
// - Reset, then iFlt_n[2] 1->0 at t=5 ms:
//   oRd_valid 2 cycles later, oRd_data={4'h3, state, 16'd5}, oFirst_code=3.
// - iFlt_n[0] and [6] fall in the same cycle:
//   records code 1 then code 7 on consecutive cycles; oFirst_code=1.
// - Depth 4, 5 distinct edges, no reads: 4 records kept, oOverflow=1.
//   Pop+push in the same cycle when full: count stays 4, no new overflow.
// - Hold iTick_1ms for 70000 ticks, then an edge: ts field = 16'hFFFF.
//   iClear_log plus an edge in the same cycle: FIFO empty, oFirst_code=0, nothing logged.
// - MSTR_FLT_LOG_IDLE_MASK_EN defined, state=4'h9, iFlt_n[1] falls: no record.
//   Same edge with state=4'h5: record code=2, state=5.
// - iFlt_n=7'h7E held low through reset release: exactly one record code=1.
//   oFault_any=1 one cycle after reset release.

Source files
------------

// File: rtl/mstr_seq_fault_log.sv
// Fault-onset logger for the master power sequencer: edge-detects 7 active-low flags,
// queues {code, state, ms timestamp} records in a FWFT FIFO. Option: MSTR_FLT_LOG_IDLE_MASK_EN.
module mstr_seq_fault_log #(
  parameter int LOG_DEPTH_W = 2,
  parameter int TS_W        = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iTick_1ms,
  input  logic [3:0]        iFSM_state,
  input  logic [6:0]        iFlt_n,
  input  logic              iClear_log,
  input  logic              iRd_ack,
  output logic              oRd_valid,
  output logic [8+TS_W-1:0] oRd_data,
  output logic [3:0]        oFirst_code,
  output logic              oFault_any,
  output logic              oOverflow
);

  localparam int         DEPTH      = 1 << LOG_DEPTH_W;
  localparam logic [3:0] STATE_IDLE = 4'h9;

  logic [6:0]           prev;
  logic [6:0]           pend;
  logic [6:0]           flt_edge;
  logic [6:0]           serve;
  logic [3:0]           serve_code;
  logic [TS_W-1:0]      ts;
  logic [LOG_DEPTH_W:0] wptr;
  logic [LOG_DEPTH_W:0] rptr;
  logic [8+TS_W-1:0]    mem [DEPTH];
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  always_comb begin
    flt_edge = prev & ~iFlt_n;
`ifdef MSTR_FLT_LOG_IDLE_MASK_EN
    if (iFSM_state == STATE_IDLE) flt_edge = '0;
`endif
  end

  // Lowest pending flag wins; the rest wait for following cycles.
  always_comb begin
    serve      = pend & (~pend + 7'd1);
    serve_code = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (pend[i]) serve_code = 4'(i + 1);
    end
  end

  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[LOG_DEPTH_W] != rptr[LOG_DEPTH_W]) &&
            (wptr[LOG_DEPTH_W-1:0] == rptr[LOG_DEPTH_W-1:0]);
    pop   = iRd_ack & ~empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
    push  = (|pend) & (~full | pop);
    drop  = (|pend) & full & ~pop;
  end

  assign oRd_valid = ~empty;
  assign oRd_data  = empty ? '0 : mem[rptr[LOG_DEPTH_W-1:0]];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      prev        <= 7'h7F;
      pend        <= '0;
      ts          <= '0;
      wptr        <= '0;
      rptr        <= '0;
      oFirst_code <= 4'd0;
      oFault_any  <= 1'b0;
      oOverflow   <= 1'b0;
    end else begin
      // prev tracks through a clear so a flag held low is not logged again.
      prev       <= iFlt_n;
      oFault_any <= ~&iFlt_n;
      if (iClear_log) begin
        pend        <= '0;
        ts          <= '0;
        wptr        <= '0;
        rptr        <= '0;
        oFirst_code <= 4'd0;
        oOverflow   <= 1'b0;
      end else begin
        pend <= (pend | flt_edge) & ~serve;
        if (iTick_1ms && (ts != '1)) ts <= ts + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        if (push) wptr <= wptr + 1'b1;
        if (push && (oFirst_code == 4'd0)) oFirst_code <= serve_code;
        if (drop) oOverflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst && !iClear_log && push) begin
      mem[wptr[LOG_DEPTH_W-1:0]] <= {serve_code, iFSM_state, ts};
    end
  end

endmodule
